// File: rtl/ln_pkg.sv
// Shared LayerNorm definitions: datapath widths and the row sequencer state set.
package ln_pkg;

  localparam int unsigned DATA_W = 8;  // signed activation width
  localparam int unsigned EX_W   = 9;  // signed mean width from the Ex unit

  typedef enum logic [2:0] {
    LOAD,
    START,
    FEED,
    WAIT,
    REPLAY
  } state_t;

endpackage

// File: rtl/ln_row_sequencer_if.sv
// Handshake bundle of the LayerNorm row sequencer.
//   s_*     : input sample stream (valid/ready, data, end-of-row marker)
//   o_ex_*  : drive to the mean unit; i_ex_* : done pulse and mean back from it
//   m_*     : replay stream of (x, mean) pairs; o_err : one-cycle error pulse
// master is the sequencer's view, slave is the surrounding environment.
interface ln_row_sequencer_if;
  import ln_pkg::*;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;

  logic              o_ex_valid;
  logic [DATA_W-1:0] o_ex_x;
  logic              i_ex_done;
  logic [EX_W-1:0]   i_ex_mean;

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_x;
  logic [EX_W-1:0]   m_mean;
  logic              m_last;

  logic              o_err;

  modport master (
    input  s_valid, s_data, s_last, i_ex_done, i_ex_mean, m_ready,
    output s_ready, o_ex_valid, o_ex_x, m_valid, m_x, m_mean, m_last, o_err
  );

  modport slave (
    output s_valid, s_data, s_last, i_ex_done, i_ex_mean, m_ready,
    input  s_ready, o_ex_valid, o_ex_x, m_valid, m_x, m_mean, m_last, o_err
  );

endinterface

// File: rtl/ln_row_buf.sv
// Row buffer: N x DATA_W register file, one synchronous write port and one
// combinational read port. Storage is not reset.
//   i_clk              : clock
//   we, waddr, wdata   : write port
//   raddr -> rdata     : combinational read port
module ln_row_buf
  import ln_pkg::*;
#(
  parameter  int unsigned N  = 8,
  localparam int unsigned AW = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge i_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ln_row_sequencer.sv
// LayerNorm mean-path row sequencer: buffers one row of N samples, frames it
// for the mean unit (priming beat + N beats), captures the mean and replays
// the row as (x, mean) pairs.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   bus (master)  : input stream, mean-unit drive/return, replay stream, o_err
module ln_row_sequencer
  import ln_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  ln_row_sequencer_if.master   bus
);

  localparam int unsigned AW = $clog2(N);
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [AW-1:0]     idx;
  logic [CW-1:0]     wait_cnt;
  logic [EX_W-1:0]   mean_q;

  logic              s_ready_q;
  logic              ex_valid_q;
  logic [DATA_W-1:0] ex_x_q;
  logic              m_valid_q;
  logic [DATA_W-1:0] m_x_q;
  logic              m_last_q;
  logic              err_q;

  logic              s_acc;
  logic              last_idx;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;

  assign s_acc    = bus.s_valid & s_ready_q;
  assign last_idx = (idx == AW'(N - 1));

  // Outputs are registered, so the buffer is read one beat ahead of idx.
  assign rd_addr = ((state == FEED) || (state == REPLAY)) ? idx + AW'(1) : '0;

  ln_row_buf #(.N(N)) u_buf (
    .i_clk (i_clk),
    .we    (s_acc),
    .waddr (idx),
    .wdata (bus.s_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= LOAD;
      idx        <= '0;
      wait_cnt   <= '0;
      mean_q     <= '0;
      s_ready_q  <= 1'b1;
      ex_valid_q <= 1'b0;
      ex_x_q     <= '0;
      m_valid_q  <= 1'b0;
      m_x_q      <= '0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // A done pulse is only meaningful while waiting for the mean.
      err_q <= bus.i_ex_done && (state != WAIT);
      case (state)
        LOAD: begin
          if (s_acc) begin
            if (bus.s_last != last_idx) err_q <= 1'b1;
            if (last_idx) begin
              idx        <= '0;
              state      <= START;
              s_ready_q  <= 1'b0;
              ex_valid_q <= 1'b1;
              ex_x_q     <= '0;
            end else begin
              idx <= idx + AW'(1);
            end
          end
        end
        START: begin
          state  <= FEED;
          ex_x_q <= rd_data;
        end
        FEED: begin
          if (last_idx) begin
            idx        <= '0;
            state      <= WAIT;
            ex_valid_q <= 1'b0;
            ex_x_q     <= '0;
            wait_cnt   <= '0;
          end else begin
            idx    <= idx + AW'(1);
            ex_x_q <= rd_data;
          end
        end
        WAIT: begin
          if (bus.i_ex_done) begin
            mean_q    <= bus.i_ex_mean;
            state     <= REPLAY;
            m_valid_q <= 1'b1;
            m_x_q     <= rd_data;
            m_last_q  <= 1'b0;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // Abort: drop the row, the mean unit has long since gone idle.
            err_q     <= 1'b1;
            state     <= LOAD;
            s_ready_q <= 1'b1;
            idx       <= '0;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        REPLAY: begin
          if (m_valid_q && bus.m_ready) begin
            if (last_idx) begin
              idx       <= '0;
              state     <= LOAD;
              s_ready_q <= 1'b1;
              m_valid_q <= 1'b0;
              m_x_q     <= '0;
              m_last_q  <= 1'b0;
            end else begin
              idx      <= idx + AW'(1);
              m_x_q    <= rd_data;
              m_last_q <= (idx == AW'(N - 2));
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.s_ready    = s_ready_q;
  assign bus.o_ex_valid = ex_valid_q;
  assign bus.o_ex_x     = ex_x_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_x        = m_x_q;
  assign bus.m_mean     = mean_q;
  assign bus.m_last     = m_last_q;
  assign bus.o_err      = err_q;

endmodule

// File: tb/tb_ln_row_sequencer.sv
// Scoreboard bench for ln_row_sequencer with a behavioural mean-unit model.
module tb_ln_row_sequencer;

  localparam int N       = 8;
  localparam int TIMEOUT = 15;

  logic i_clk  = 1'b0;
  logic i_rstn = 1'b0;
  always #5 i_clk = ~i_clk;

  ln_row_sequencer_if bus ();

  ln_row_sequencer #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .bus    (bus)
  );

  typedef struct {
    int x;
    int mean;
    int last;
  } beat_t;

  int    checks   = 0;
  int    failures = 0;
  int    cyc      = 0;
  int    err_cnt  = 0;
  int    mv_cycles = 0;
  beat_t exp_q[$];
  int    exp_ex[$];
  int    row[N];

  bit    model_never = 1'b0;
  logic  model_done  = 1'b0;
  logic  spur_done   = 1'b0;
  logic [8:0] model_mean = '0;
  int    mr_mode      = 0;
  int    first_mv_cyc = -1;
  int    last_acc     = 0;

  assign bus.i_ex_done = model_done | spur_done;
  assign bus.i_ex_mean = model_mean;

  always @(posedge i_clk) cyc <= cyc + 1;
  always @(negedge i_clk) if (i_rstn && bus.o_err) err_cnt <= err_cnt + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Mean unit: priming beat, N accumulated beats, done two cycles later with floor mean.
  bit primed = 1'b0;
  int acc_n = 0, acc_sum = 0, cd = 0, pend_mean = 0;
  initial begin : mean_model
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        primed = 1'b0; acc_n = 0; acc_sum = 0; cd = 0; model_done = 1'b0;
        continue;
      end
      if (cd > 0) begin
        cd--;
        model_done = (cd == 0);
        if (cd == 0) model_mean = 9'(pend_mean);
      end else begin
        model_done = 1'b0;
      end
      if (bus.o_ex_valid) begin
        if (exp_ex.size() == 0) chk("ex_unexpected_beat", 1, 0);
        else chk("ex_x", $signed(bus.o_ex_x), exp_ex.pop_front());
        if (!primed) begin
          primed = 1'b1; acc_n = 0; acc_sum = 0;
        end else begin
          acc_sum += $signed(bus.o_ex_x);
          acc_n++;
          if (acc_n == N) begin
            primed = 1'b0;
            pend_mean = acc_sum >>> $clog2(N);
            if (!model_never) cd = 2;
          end
        end
      end else begin
        chk("ex_x_idle_zero", bus.o_ex_x, 0);
      end
    end
  end

  // Replay monitor: drives m_ready, pops the scoreboard on each handshake.
  logic       pstall = 1'b0, pmv = 1'b0, pl = 1'b0;
  logic [7:0] px = '0;
  logic [8:0] pm = '0;
  int         pat = 0;
  initial begin : m_mon
    bus.m_ready = 1'b1;
    forever begin
      @(negedge i_clk);
      if (!i_rstn) begin
        pstall = 1'b0; pmv = 1'b0;
        continue;
      end
      if (!bus.m_valid) chk("m_x_idle_zero", bus.m_x, 0);
      else begin
        mv_cycles++;
        chk("s_ready_low_during_replay", bus.s_ready, 0);
      end
      if (pstall) begin
        chk("stall_m_valid", bus.m_valid, 1);
        chk("stall_m_x", bus.m_x, px);
        chk("stall_m_mean", bus.m_mean, pm);
        chk("stall_m_last", bus.m_last, pl);
      end
      if (bus.m_valid && !pmv) first_mv_cyc = cyc;
      case (mr_mode)
        0: bus.m_ready = 1'b1;
        1: begin
          bus.m_ready = (pat % 3 == 0);
          if (bus.m_valid) pat++;
        end
        default: bus.m_ready = 1'($urandom_range(1));
      endcase
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) chk("m_unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("m_x", $signed(bus.m_x), e.x);
          chk("m_mean", $signed(bus.m_mean), e.mean);
          chk("m_last", bus.m_last, e.last);
        end
      end
      pstall = bus.m_valid && !bus.m_ready;
      pmv = bus.m_valid; px = bus.m_x; pm = bus.m_mean; pl = bus.m_last;
    end
  end

  task automatic send_row(input int last_pos, input bit gaps, input bit expect_replay);
    int sum = 0;
    int mean;
    int w;
    for (int i = 0; i < N; i++) sum += row[i];
    mean = sum >>> $clog2(N);
    exp_ex.push_back(0);
    for (int i = 0; i < N; i++) exp_ex.push_back(row[i]);
    if (expect_replay)
      for (int i = 0; i < N; i++) exp_q.push_back('{row[i], mean, int'(i == N - 1)});
    @(negedge i_clk);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g = int'($urandom_range(2));
        repeat (g) begin bus.s_valid = 1'b0; @(negedge i_clk); end
      end
      bus.s_valid = 1'b1;
      bus.s_data  = 8'(row[i]);
      bus.s_last  = (i == last_pos);
      w = 0;
      while (!bus.s_ready && w < 2000) begin @(negedge i_clk); w++; end
      if (w >= 2000) begin
        chk("s_ready_wait_bound", 0, 1);
        bus.s_valid = 1'b0;
        return;
      end
      if (i == N - 1) last_acc = cyc;
      @(negedge i_clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int w = 0;
    while ((exp_q.size() != 0 || exp_ex.size() != 0) && w < 2000) begin
      @(negedge i_clk); w++;
    end
    chk(nm, exp_q.size() + exp_ex.size(), 0);
    repeat (3) @(negedge i_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1);
    chk({tag, "_o_ex_valid"}, bus.o_ex_valid, 0);
    chk({tag, "_o_ex_x"}, bus.o_ex_x, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_x"}, bus.m_x, 0);
    chk({tag, "_m_mean"}, bus.m_mean, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
    chk({tag, "_o_err"}, bus.o_err, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int e0, m0, w;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rstn = 1'b1;

    // Ascending row, full-rate replay, latency check.
    for (int i = 0; i < N; i++) row[i] = i + 1;
    mr_mode = 0; first_mv_cyc = -1; e0 = err_cnt;
    send_row(N - 1, 1'b0, 1'b1);
    wait_drain("row_1to8_drained");
    chk("latency_last_accept_to_m_valid", first_mv_cyc - last_acc, N + 4);
    chk("row_1to8_no_err", err_cnt - e0, 0);

    // Extreme negative row, then alternating +/-100.
    e0 = err_cnt;
    for (int i = 0; i < N; i++) row[i] = -127;
    send_row(N - 1, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) row[i] = (i % 2 == 0) ? 100 : -100;
    send_row(N - 1, 1'b0, 1'b1);
    wait_drain("neg_alt_drained");
    chk("neg_alt_no_err", err_cnt - e0, 0);

    // Back-pressure pattern 1,0,0 on m_ready.
    for (int i = 0; i < N; i++) row[i] = i + 1;
    pat = 0; mr_mode = 1; e0 = err_cnt;
    send_row(N - 1, 1'b0, 1'b1);
    wait_drain("stall_drained");
    chk("stall_no_err", err_cnt - e0, 0);
    mr_mode = 0;

    // s_last on beat 3 only: two error pulses, full replay.
    e0 = err_cnt;
    send_row(3, 1'b0, 1'b1);
    wait_drain("slast_drained");
    chk("slast_err_pulses", err_cnt - e0, 2);

    // Mean unit never completes: timeout abort back to LOAD.
    for (int i = 0; i < N; i++) row[i] = int'($urandom_range(254)) - 127;
    model_never = 1'b1; e0 = err_cnt; m0 = mv_cycles;
    send_row(N - 1, 1'b0, 1'b0);
    w = 0;
    while (err_cnt == e0 && w < 200) begin @(negedge i_clk); w++; end
    repeat (3) @(negedge i_clk);
    chk("timeout_err_pulse", err_cnt - e0, 1);
    chk("timeout_s_ready", bus.s_ready, 1);
    chk("timeout_no_replay", mv_cycles - m0, 0);
    chk("timeout_feed_drained", exp_ex.size(), 0);
    model_never = 1'b0;

    // Spurious done while idle in LOAD.
    e0 = err_cnt;
    @(negedge i_clk); spur_done = 1'b1;
    @(negedge i_clk); spur_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("spurious_done_err", err_cnt - e0, 1);
    chk("spurious_done_s_ready", bus.s_ready, 1);
    e0 = err_cnt;
    for (int i = 0; i < N; i++) row[i] = int'($urandom_range(254)) - 127;
    send_row(N - 1, 1'b0, 1'b1);
    wait_drain("after_spurious_drained");
    chk("after_spurious_no_err", err_cnt - e0, 0);

    // Reset during FEED beat 4, then a clean row.
    for (int i = 0; i < N; i++) row[i] = int'($urandom_range(254)) - 127;
    m0 = mv_cycles;
    send_row(N - 1, 1'b0, 1'b1);
    repeat (5) @(negedge i_clk);
    chk("pre_reset_in_feed", bus.o_ex_valid, 1);
    i_rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    exp_ex.delete();
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("midreset_no_replay", mv_cycles - m0, 0);
    e0 = err_cnt;
    for (int i = 0; i < N; i++) row[i] = int'($urandom_range(254)) - 127;
    send_row(N - 1, 1'b0, 1'b1);
    wait_drain("after_reset_drained");
    chk("after_reset_no_err", err_cnt - e0, 0);

    // Random rows with input gaps and random back-pressure.
    mr_mode = 2; e0 = err_cnt;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) row[i] = int'($urandom_range(254)) - 127;
      send_row(N - 1, 1'b1, 1'b1);
    end
    wait_drain("random_drained");
    chk("random_no_err", err_cnt - e0, 0);
    mr_mode = 0;

    repeat (2) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
